// File: rtl/sdram_rw_arbiter.sv
// Shares the single SDRAM controller port between the write-FIFO drain path and the
// read-FIFO fill path, issuing round-robin bursts from two circular address pointers.
module sdram_rw_arbiter #(
  parameter int unsigned SC_BL  = 8,
  parameter int unsigned RD_THR = 128,
  parameter int unsigned COL_W  = 9,
  parameter int unsigned ROW_W  = 13,
  parameter int unsigned BANK_W = 2
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              Init_done,
  input  logic                              Wr_load,
  input  logic [BANK_W+ROW_W+COL_W-1:0]     Wr_addr,
  input  logic [BANK_W+ROW_W+COL_W-1:0]     Wr_max_addr,
  input  logic [7:0]                        Wr_fifo_rduse,
  input  logic                              Rd_load,
  input  logic [BANK_W+ROW_W+COL_W-1:0]     Rd_addr,
  input  logic [BANK_W+ROW_W+COL_W-1:0]     Rd_max_addr,
  input  logic [7:0]                        Rd_fifo_wruse,
  input  logic                              Wdata_done,
  input  logic                              Rdata_done,
  output logic                              Sd_wr,
  output logic                              Sd_rd,
  output logic [COL_W-1:0]                  Sd_caddr,
  output logic [ROW_W-1:0]                  Sd_raddr,
  output logic [BANK_W-1:0]                 Sd_baddr,
  output logic                              Busy
);

  localparam int unsigned AW = BANK_W + ROW_W + COL_W;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWrBurst = 2'd1;
  localparam logic [1:0] StRdBurst = 2'd2;

  localparam logic [AW-1:0] BurstInc   = AW'(SC_BL);
  localparam logic [7:0]    BurstWords = 8'(SC_BL);
  localparam logic [7:0]    RdThr      = 8'(RD_THR);

  logic [1:0]    state_q, state_d;
  logic          last_wr_q, last_wr_d;  // 1: most recent grant went to the write side
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  logic wr_req, rd_req;
  logic wr_fin, rd_fin;

  assign wr_req = Init_done & ~Wr_load & (Wr_fifo_rduse >= BurstWords);
  assign rd_req = Init_done & ~Rd_load & (Rd_fifo_wruse < RdThr);

  // Done pulses only count in the matching burst state.
  assign wr_fin = (state_q == StWrBurst) & Wdata_done;
  assign rd_fin = (state_q == StRdBurst) & Rdata_done;

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    addr_d    = addr_q;
    unique case (state_q)
      StIdle: begin
        if (wr_req && (!rd_req || !last_wr_q)) begin
          state_d   = StWrBurst;
          addr_d    = wr_ptr_q;
          last_wr_d = 1'b1;
        end else if (rd_req) begin
          state_d   = StRdBurst;
          addr_d    = rd_ptr_q;
          last_wr_d = 1'b0;
        end
      end
      StWrBurst: if (wr_fin) state_d = StIdle;
      StRdBurst: if (rd_fin) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Load beats a coincident done, so a reload is never advanced in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (Wr_load) begin
      wr_ptr_d = Wr_addr;
    end else if (wr_fin) begin
      wr_ptr_d = (wr_ptr_q == Wr_max_addr - BurstInc) ? Wr_addr : wr_ptr_q + BurstInc;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (Rd_load) begin
      rd_ptr_d = Rd_addr;
    end else if (rd_fin) begin
      rd_ptr_d = (rd_ptr_q == Rd_max_addr - BurstInc) ? Rd_addr : rd_ptr_q + BurstInc;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= StIdle;
      last_wr_q <= 1'b0;
      addr_q    <= '0;
      wr_ptr_q  <= Wr_addr;
      rd_ptr_q  <= Rd_addr;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      addr_q    <= addr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  assign Sd_wr    = (state_q == StWrBurst);
  assign Sd_rd    = (state_q == StRdBurst);
  assign Busy     = (state_q != StIdle);
  assign Sd_caddr = addr_q[COL_W-1:0];
  assign Sd_raddr = addr_q[COL_W+ROW_W-1:COL_W];
  assign Sd_baddr = addr_q[AW-1:COL_W+ROW_W];

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Bench for sdram_rw_arbiter: directed vector table followed by randomized traffic
// checked against a transaction-level reference model.
module tb_sdram_rw_arbiter;

  logic        Clk = 1'b0;
  logic        Rst, Init_done, Wr_load, Rd_load, Wdata_done, Rdata_done;
  logic [23:0] Wr_addr, Wr_max_addr, Rd_addr, Rd_max_addr;
  logic [7:0]  Wr_fifo_rduse, Rd_fifo_wruse;
  logic        Sd_wr, Sd_rd, Busy;
  logic [8:0]  Sd_caddr;
  logic [12:0] Sd_raddr;
  logic [1:0]  Sd_baddr;
  logic [23:0] sd_addr;

  assign sd_addr = {Sd_baddr, Sd_raddr, Sd_caddr};

  always #5 Clk = ~Clk;

  sdram_rw_arbiter dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Init_done     (Init_done),
    .Wr_load       (Wr_load),
    .Wr_addr       (Wr_addr),
    .Wr_max_addr   (Wr_max_addr),
    .Wr_fifo_rduse (Wr_fifo_rduse),
    .Rd_load       (Rd_load),
    .Rd_addr       (Rd_addr),
    .Rd_max_addr   (Rd_max_addr),
    .Rd_fifo_wruse (Rd_fifo_wruse),
    .Wdata_done    (Wdata_done),
    .Rdata_done    (Rdata_done),
    .Sd_wr         (Sd_wr),
    .Sd_rd         (Sd_rd),
    .Sd_caddr      (Sd_caddr),
    .Sd_raddr      (Sd_raddr),
    .Sd_baddr      (Sd_baddr),
    .Busy          (Busy)
  );

  typedef struct {
    logic        rst, init, wl, rl;
    logic [7:0]  wu, ru;
    logic        wd, rdn;
    logic        exp_wr, exp_rd;
    logic [23:0] exp_addr;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic add(input logic rst, input logic init, input logic wl, input logic rl,
                     input logic [7:0] wu, input logic [7:0] ru, input logic wd,
                     input logic rdn, input logic ew, input logic er,
                     input logic [23:0] ea);
    vec_t v;
    v.rst = rst; v.init = init; v.wl = wl; v.rl = rl; v.wu = wu; v.ru = ru;
    v.wd = wd; v.rdn = rdn; v.exp_wr = ew; v.exp_rd = er; v.exp_addr = ea;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state (transaction level: which side owns the port, pointer offsets).
  int unsigned wa, wm, ra, rm, wptr, rptr;
  int          side;     // 0 none, 1 write, 2 read
  bit          last_w;
  int unsigned m_addr;

  task automatic new_region(output int unsigned s, output int unsigned m);
    s = $urandom_range(0, 24'h1FFFF0) * 8;
    m = s + 8 * $urandom_range(1, 4);
  endtask

  task automatic model_step(input bit rst, input bit init, input bit wl, input bit rl,
                            input int unsigned wu, input int unsigned ru,
                            input bit wd, input bit rdn);
    bit wreq, rreq, wfin, rfin;
    if (rst) begin
      side = 0; wptr = wa; rptr = ra; last_w = 0;
      return;
    end
    wreq = init && !wl && (wu >= 8);
    rreq = init && !rl && (ru < 128);
    wfin = (side == 1) && wd;
    rfin = (side == 2) && rdn;
    if (side == 0) begin
      if (wreq && rreq) side = last_w ? 2 : 1;
      else if (wreq)    side = 1;
      else if (rreq)    side = 2;
      if (side != 0) begin
        m_addr = (side == 1) ? wptr : rptr;
        last_w = (side == 1);
      end
    end else if (wfin || rfin) begin
      side = 0;
    end
    if (wl)        wptr = wa;
    else if (wfin) wptr = wa + (wptr - wa + 8) % (wm - wa);
    if (rl)        rptr = ra;
    else if (rfin) rptr = ra + (rptr - ra + 8) % (rm - ra);
  endtask

  initial begin
    Rst = 1; Init_done = 1; Wr_load = 0; Rd_load = 0; Wdata_done = 0; Rdata_done = 0;
    Wr_addr = 24'h0; Wr_max_addr = 24'd32; Rd_addr = 24'h3FFFF8; Rd_max_addr = 24'h400008;
    Wr_fifo_rduse = 8'd8; Rd_fifo_wruse = 8'd200;

    //  rst in wl rl  wu   ru  wd rd  ew er addr
    add(1, 1, 0, 0, 8, 200, 0, 0, 0, 0, 24'h0);       // reset
    add(0, 1, 0, 0, 8, 200, 0, 0, 1, 0, 24'h0);       // write grant right after reset
    add(0, 1, 0, 0, 8, 200, 0, 0, 1, 0, 24'h0);       // held until done
    add(0, 1, 0, 0, 8, 200, 1, 0, 0, 0, 24'h0);
    add(0, 1, 0, 0, 8, 200, 0, 0, 1, 0, 24'd8);
    add(0, 1, 0, 0, 8, 200, 1, 0, 0, 0, 24'h0);
    add(0, 1, 0, 0, 8, 200, 0, 0, 1, 0, 24'd16);
    add(0, 1, 0, 0, 8, 200, 1, 0, 0, 0, 24'h0);
    add(0, 1, 0, 0, 8, 200, 0, 0, 1, 0, 24'd24);
    add(0, 1, 0, 0, 8, 200, 1, 0, 0, 0, 24'h0);
    add(0, 1, 0, 0, 8, 200, 0, 0, 1, 0, 24'd0);       // wrap
    add(0, 1, 0, 0, 8, 200, 1, 0, 0, 0, 24'h0);
    add(0, 1, 0, 0, 8,   0, 0, 0, 0, 1, 24'h3FFFF8);  // tie, last was write -> read
    add(0, 1, 0, 0, 8,   0, 0, 1, 0, 0, 24'h0);
    add(0, 1, 0, 0, 8,   0, 0, 0, 1, 0, 24'd8);
    add(0, 1, 0, 0, 8,   0, 1, 0, 0, 0, 24'h0);
    add(0, 1, 0, 0, 8,   0, 0, 0, 0, 1, 24'h400000);  // bank boundary
    add(0, 1, 0, 0, 8,   0, 0, 1, 0, 0, 24'h0);
    add(0, 1, 0, 0, 8,   0, 0, 0, 1, 0, 24'd16);
    add(0, 1, 0, 0, 8,   0, 1, 0, 0, 0, 24'h0);
    add(0, 1, 0, 0, 8,   0, 0, 0, 0, 1, 24'h3FFFF8);
    add(1, 1, 0, 0, 8,   0, 0, 0, 0, 0, 24'h0);       // reset mid read burst
    add(0, 0, 0, 0, 8,   0, 0, 0, 0, 0, 24'h0);       // init not done
    add(0, 0, 0, 0, 8,   0, 0, 0, 0, 0, 24'h0);
    add(0, 1, 0, 0, 8, 200, 0, 0, 1, 0, 24'h0);       // pointer reloaded by reset
    add(0, 1, 1, 0, 8, 200, 1, 0, 0, 0, 24'h0);       // load with done
    add(0, 1, 1, 0, 8, 200, 0, 0, 0, 0, 24'h0);       // no grant while loading
    add(0, 1, 0, 0, 8, 200, 0, 0, 1, 0, 24'h0);       // no advance
    add(0, 1, 0, 0, 8, 200, 1, 0, 0, 0, 24'h0);
    add(0, 1, 0, 0, 0, 200, 0, 1, 0, 0, 24'h0);       // stray read done ignored
    add(0, 1, 0, 1, 8,   0, 0, 0, 1, 0, 24'd8);       // read blocked, write goes
    add(0, 1, 0, 1, 8,   0, 1, 0, 0, 0, 24'h0);
    add(0, 1, 0, 0, 0,   0, 0, 0, 0, 1, 24'h3FFFF8);
    add(0, 1, 0, 0, 0, 200, 0, 1, 0, 0, 24'h0);
    add(0, 1, 0, 0, 7, 128, 0, 0, 0, 0, 24'h0);       // both just below threshold
    add(0, 1, 0, 0, 7, 127, 0, 0, 0, 1, 24'h400000);
    add(0, 1, 0, 0, 7, 127, 0, 1, 0, 0, 24'h0);

    foreach (vecs[i]) begin
      Rst = vecs[i].rst; Init_done = vecs[i].init; Wr_load = vecs[i].wl;
      Rd_load = vecs[i].rl; Wr_fifo_rduse = vecs[i].wu; Rd_fifo_wruse = vecs[i].ru;
      Wdata_done = vecs[i].wd; Rdata_done = vecs[i].rdn;
      @(posedge Clk);
      #1;
      check($sformatf("vec%0d Sd_wr", i), 32'(Sd_wr), 32'(vecs[i].exp_wr));
      check($sformatf("vec%0d Sd_rd", i), 32'(Sd_rd), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d Busy", i), 32'(Busy), 32'(vecs[i].exp_wr | vecs[i].exp_rd));
      if (vecs[i].exp_wr || vecs[i].exp_rd || vecs[i].rst)
        check($sformatf("vec%0d addr", i), 32'(sd_addr), 32'(vecs[i].exp_addr));
    end

    // Randomized traffic against the reference model.
    new_region(wa, wm);
    new_region(ra, rm);
    for (int c = 0; c < 3000; c++) begin
      bit r_rst, r_init, r_wl, r_rl, r_wd, r_rd;
      int unsigned r_wu, r_ru;
      r_rst  = (c == 0) || ($urandom_range(0, 99) == 0);
      r_init = ($urandom_range(0, 15) != 0);
      r_wl   = ($urandom_range(0, 31) == 0);
      r_rl   = ($urandom_range(0, 31) == 0);
      r_wu   = $urandom_range(0, 16);
      r_ru   = $urandom_range(110, 145);
      r_wd   = ($urandom_range(0, 3) == 0);
      r_rd   = ($urandom_range(0, 3) == 0);
      if (r_rst || r_wl) new_region(wa, wm);
      if (r_rst || r_rl) new_region(ra, rm);
      Rst = r_rst; Init_done = r_init; Wr_load = r_wl; Rd_load = r_rl;
      Wr_fifo_rduse = 8'(r_wu); Rd_fifo_wruse = 8'(r_ru);
      Wdata_done = r_wd; Rdata_done = r_rd;
      Wr_addr = 24'(wa); Wr_max_addr = 24'(wm); Rd_addr = 24'(ra); Rd_max_addr = 24'(rm);
      model_step(r_rst, r_init, r_wl, r_rl, r_wu, r_ru, r_wd, r_rd);
      @(posedge Clk);
      #1;
      check("rand Sd_wr", 32'(Sd_wr), 32'(side == 1));
      check("rand Sd_rd", 32'(Sd_rd), 32'(side == 2));
      check("rand Busy", 32'(Busy), 32'(side != 0));
      check("rand exclusive", 32'(Sd_wr & Sd_rd), 32'(0));
      if (side != 0) check("rand addr", 32'(sd_addr), m_addr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
